jtcps2_eeprom: RTL
==================

JTCPS2_EEPROM -- requirements
Module: jtcps2_eeprom

Interface
REQ-001 Parameter AW, default 6: word address width (64 words, 93C46 x16 organisation).
REQ-002 Parameter DW, default 16: word width.
REQ-003 Parameter BUSY_CYCLES, default 1024: clk cycles the device reports busy after any program/erase command.
REQ-004 One clock; reset is synchronous and active-low. Ports: clk in 1, clock; rstn in 1, reset.
REQ-005 eeprom_scs  in  1  chip select from main CPU latch, active high.
REQ-006 eeprom_sclk  in  1  serial clock from main CPU latch; sampled in clk domain.
REQ-007 eeprom_sdi  in  1  serial data into device.
REQ-008 eeprom_sdo  out  1  serial data/ready to main CPU input port.
REQ-009 dump_addr  in  AW  NVRAM load/save word address.
REQ-010 dump_din  in  DW  NVRAM load data.
REQ-011 dump_we  in  1  NVRAM load write strobe, one word per cycle.
REQ-012 dump_dout  out  DW  word at dump_addr, one-cycle latency.
REQ-013 dump_flag  out  1  high once the serial side has modified contents.
REQ-014 dump_clr  in  1  clears dump_flag.

Function
REQ-015 sclk rising edge = current sampled sclk high, previous sample low; only edges with eeprom_scs high act.
REQ-016 States: IDLE, CMD, READ, WRDATA, WAITCS, BUSY.
REQ-017 IDLE: sdi=0 edges ignored; sdi=1 edge -> CMD, bit counter cleared.
REQ-018 CMD: shifts 2 opcode + AW address bits MSB first; decode on the (2+AW)th edge.
REQ-019 Opcode 10 READ -> READ; 01 WRITE, 11 ERASE, 00/01xxxx WRAL -> WRDATA or WAITCS; 00/11xxxx EWEN, 00/00xxxx EWDS, 00/10xxxx ERAL -> WAITCS.
REQ-020 READ: sdo=0 (dummy bit) from decode until next edge, then DW data bits MSB first, each bit valid after the edge that shifts it; after DW bits address increments (wrap 2^AW-1 -> 0) and next word streams without a dummy bit.
REQ-021 WRDATA (WRITE, WRAL): shifts DW bits, then WAITCS; extra edges ignored.
REQ-022 EWEN sets write-enable flag, EWDS clears it; effective at decode.
REQ-023 scs falling in WAITCS with a program command (WRITE, ERASE, WRAL, ERAL) and write-enable set: commit, enter BUSY; with write-enable clear: IDLE, memory unchanged.
REQ-024 Commit: WRITE stores data; ERASE stores all-ones; WRAL/ERAL write every word, one word per clk, during BUSY.
REQ-025 BUSY lasts BUSY_CYCLES clk (>= 2^AW), then IDLE; edges ignored while BUSY.
REQ-026 sdo: READ as REQ-020; BUSY with scs high = 0; otherwise 1.
REQ-027 scs low outside BUSY/WAITCS, or mid-command: abort to IDLE, no memory change.
REQ-028 dump_we writes any time; same-cycle same-address serial commit wins.
REQ-029 dump_flag set on every commit, cleared by dump_clr; simultaneous set and clear -> set.

Reset
REQ-030 rstn low: state IDLE, write-enable 0, eeprom_sdo 1, dump_flag 0, counters 0; memory array not cleared; reset during BUSY abandons remaining ERAL/WRAL words.

Verification
REQ-031 Load word 5 = 0xA55A via dump port; serial READ addr 5 -> sdo: dummy 0 then 1010010101011010.
REQ-032 WRITE addr 3 data 0x1234 without EWEN -> dump_dout at addr 3 unchanged, dump_flag 0.
REQ-033 EWEN, WRITE addr 3 0x1234, scs low -> sdo 0 while scs high for BUSY_CYCLES, then 1; addr 3 = 0x1234; dump_flag 1.
REQ-034 EWEN, ERAL -> after BUSY all 64 words 0xFFFF; dump_clr -> dump_flag 0.
REQ-035 READ addr 63 with 32 data clocks -> word 63 then word 0, no dummy bit between.
REQ-036 rstn low mid-WRITE shift -> sdo 1, IDLE; memory unchanged; write-enable 0.

Source files
------------

// File: rtl/jtcps2_eeprom.sv
// -----------------------------------------------------------------------------
// jtcps2_eeprom
// Serial EEPROM model of a 93C46-style device in x16 organisation, as seen by
// the CPS2 main CPU through its output latch (chip select, serial clock and
// serial data in) and an input port bit (serial data out / ready).
// A second, parallel "dump" port lets the host load or save the whole array
// as NVRAM contents. The dump port also reports whether the serial side has
// modified the array since the flag was last cleared.
//
// Ports
//   clk          system clock; all serial inputs are oversampled with it
//   rstn         synchronous active-low reset
//   eeprom_scs   chip select, active high
//   eeprom_sclk  serial clock (rising edges detected in clk domain)
//   eeprom_sdi   serial data into the device
//   eeprom_sdo   serial data out / ready (0 = busy while selected)
//   dump_addr    NVRAM word address
//   dump_din     NVRAM load data
//   dump_we      NVRAM load write strobe, one word per clk
//   dump_dout    word at dump_addr, one clk latency
//   dump_flag    set whenever the serial side commits a program/erase
//   dump_clr     clears dump_flag (a simultaneous commit wins)
// -----------------------------------------------------------------------------
module jtcps2_eeprom #(
    parameter int AW          = 6,
    parameter int DW          = 16,
    parameter int BUSY_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          eeprom_scs,
    input  logic          eeprom_sclk,
    input  logic          eeprom_sdi,
    output logic          eeprom_sdo,
    input  logic [AW-1:0] dump_addr,
    input  logic [DW-1:0] dump_din,
    input  logic          dump_we,
    output logic [DW-1:0] dump_dout,
    output logic          dump_flag,
    input  logic          dump_clr
);

    // Controller states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_WRDATA = 3'd3;
    localparam logic [2:0] ST_WAITCS = 3'd4;
    localparam logic [2:0] ST_BUSY   = 3'd5;

    // Pending program operation latched at command decode
    localparam logic [2:0] PG_NONE  = 3'd0;
    localparam logic [2:0] PG_WRITE = 3'd1;
    localparam logic [2:0] PG_ERASE = 3'd2;
    localparam logic [2:0] PG_WRAL  = 3'd3;
    localparam logic [2:0] PG_ERAL  = 3'd4;

    // Bit counter covers both the command field (2+AW) and a data word (DW)
    localparam int CW = $clog2(DW + AW + 2) + 1;
    localparam int BW = $clog2(BUSY_CYCLES + 1);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(AW + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
    localparam logic [BW-1:0] BUSY_ZERO = BW'(0);
    localparam logic [BW-1:0] BUSY_ONE  = BW'(1);
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_CYCLES - 1);
    localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
    localparam logic [DW-1:0] WORD_ONES = {DW{1'b1}};
    localparam logic [DW-1:0] WORD_ZERO = {DW{1'b0}};

    // Storage array; never reset so NVRAM contents survive a reset
    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // Input samplers
    logic          sclk_q_r;
    logic          sclk_p_r;
    logic          scs_q_r;
    logic          sdi_q_r;

    // Controller registers
    logic [2:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [AW:0]   cmd_sr_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_r;
    logic [2:0]    prog_r;
    logic          we_en_r;
    logic [BW-1:0] busy_cnt_r;
    logic          fill_act_r;
    logic [AW-1:0] fill_addr_r;
    logic          rd_bit_r;
    logic          sdo_r;
    logic          flag_r;
    logic [DW-1:0] dout_r;

    // Combinational helpers
    logic          edge_s;
    logic [AW+1:0] cmd_word_s;
    logic [1:0]    op_s;
    logic [AW-1:0] cmd_addr_s;
    logic [1:0]    sub_s;
    logic [AW-1:0] addr_inc_s;
    logic          commit_s;
    logic          ser_we_s;
    logic [AW-1:0] ser_addr_s;
    logic [DW-1:0] ser_data_s;

    // Serial clock rising edge, qualified by chip select
    assign edge_s     = sclk_q_r & ~sclk_p_r & scs_q_r;
    // Full command word including the bit arriving on this edge
    assign cmd_word_s = {cmd_sr_r, sdi_q_r};
    assign op_s       = cmd_word_s[AW+1:AW];
    assign cmd_addr_s = cmd_word_s[AW-1:0];
    // For opcode 00 the two address MSBs select the sub-command
    assign sub_s      = cmd_word_s[AW-1:AW-2];
    assign addr_inc_s = addr_r + ADDR_ONE;
    // Deselect in WAITCS with a program op pending and writes enabled
    assign commit_s   = (state_r == ST_WAITCS) & ~scs_q_r & we_en_r & (prog_r != PG_NONE);

    // Serial-side memory write port: single-word commit or bulk fill
    always_comb begin
        ser_we_s   = 1'b0;
        ser_addr_s = ADDR_ZERO;
        ser_data_s = WORD_ZERO;
        if (!rstn) begin
            ser_we_s = 1'b0;
        end else if (commit_s && (prog_r == PG_WRITE || prog_r == PG_ERASE)) begin
            ser_we_s   = 1'b1;
            ser_addr_s = addr_r;
            ser_data_s = (prog_r == PG_WRITE) ? data_r : WORD_ONES;
        end else if (state_r == ST_BUSY && fill_act_r) begin
            ser_we_s   = 1'b1;
            ser_addr_s = fill_addr_r;
            ser_data_s = data_r;
        end else begin
            ser_we_s = 1'b0;
        end
    end

    // Memory array writes (serial wins on an address clash) and dump read port
    always_ff @(posedge clk) begin
        if (ser_we_s) begin
            mem_r[ser_addr_s] <= ser_data_s;
        end
        if (dump_we && !(ser_we_s && ser_addr_s == dump_addr)) begin
            mem_r[dump_addr] <= dump_din;
        end
        dout_r <= mem_r[dump_addr];
    end

    // Input sampling, serial protocol controller, busy timer and outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_q_r    <= 1'b0;
            sclk_p_r    <= 1'b0;
            scs_q_r     <= 1'b0;
            sdi_q_r     <= 1'b0;
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            cmd_sr_r    <= {(AW+1){1'b0}};
            addr_r      <= ADDR_ZERO;
            data_r      <= WORD_ZERO;
            prog_r      <= PG_NONE;
            we_en_r     <= 1'b0;
            busy_cnt_r  <= BUSY_ZERO;
            fill_act_r  <= 1'b0;
            fill_addr_r <= ADDR_ZERO;
            rd_bit_r    <= 1'b0;
            sdo_r       <= 1'b1;
            flag_r      <= 1'b0;
        end else begin
            sclk_q_r <= eeprom_sclk;
            sclk_p_r <= sclk_q_r;
            scs_q_r  <= eeprom_scs;
            sdi_q_r  <= eeprom_sdi;

            // A commit on the same cycle as a clear keeps the flag set
            if (commit_s) begin
                flag_r <= 1'b1;
            end else if (dump_clr) begin
                flag_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    // Leading zeros are ignored; a one is the start bit
                    if (edge_s && sdi_q_r) begin
                        state_r <= ST_CMD;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_CMD: begin
                    if (!scs_q_r) begin
                        state_r <= ST_IDLE;
                    end else if (edge_s) begin
                        cmd_sr_r <= cmd_word_s[AW:0];
                        if (cnt_r == CMD_LAST) begin
                            cnt_r  <= CNT_ZERO;
                            prog_r <= PG_NONE;
                            case (op_s)
                                2'b10: begin
                                    state_r  <= ST_READ;
                                    addr_r   <= cmd_addr_s;
                                    data_r   <= mem_r[cmd_addr_s];
                                    rd_bit_r <= 1'b0;     // dummy bit
                                end
                                2'b01: begin
                                    state_r <= ST_WRDATA;
                                    addr_r  <= cmd_addr_s;
                                    prog_r  <= PG_WRITE;
                                end
                                2'b11: begin
                                    state_r <= ST_WAITCS;
                                    addr_r  <= cmd_addr_s;
                                    prog_r  <= PG_ERASE;
                                end
                                2'b00: begin
                                    case (sub_s)
                                        2'b01: begin
                                            state_r <= ST_WRDATA;
                                            prog_r  <= PG_WRAL;
                                        end
                                        2'b11: begin
                                            state_r <= ST_WAITCS;
                                            we_en_r <= 1'b1;
                                        end
                                        2'b00: begin
                                            state_r <= ST_WAITCS;
                                            we_en_r <= 1'b0;
                                        end
                                        2'b10: begin
                                            state_r <= ST_WAITCS;
                                            prog_r  <= PG_ERAL;
                                        end
                                        default: state_r <= ST_IDLE;
                                    endcase
                                end
                                default: state_r <= ST_IDLE;
                            endcase
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_READ: begin
                    if (!scs_q_r) begin
                        state_r <= ST_IDLE;
                    end else if (edge_s) begin
                        rd_bit_r <= data_r[DW-1];
                        // After the last bit, stream the next word with no dummy bit
                        if (cnt_r == DATA_LAST) begin
                            cnt_r  <= CNT_ZERO;
                            addr_r <= addr_inc_s;
                            data_r <= mem_r[addr_inc_s];
                        end else begin
                            cnt_r  <= cnt_r + CNT_ONE;
                            data_r <= {data_r[DW-2:0], 1'b0};
                        end
                    end
                end
                ST_WRDATA: begin
                    if (!scs_q_r) begin
                        state_r <= ST_IDLE;
                    end else if (edge_s) begin
                        data_r <= {data_r[DW-2:0], sdi_q_r};
                        if (cnt_r == DATA_LAST) begin
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_WAITCS;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_WAITCS: begin
                    // Serial edges are ignored here; only deselect matters
                    if (!scs_q_r) begin
                        if (commit_s) begin
                            state_r     <= ST_BUSY;
                            busy_cnt_r  <= BUSY_ZERO;
                            fill_addr_r <= ADDR_ZERO;
                            fill_act_r  <= (prog_r == PG_WRAL) || (prog_r == PG_ERAL);
                            if (prog_r == PG_ERAL) begin
                                data_r <= WORD_ONES;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_BUSY: begin
                    // Bulk operations write one word per clk during the busy time
                    if (fill_act_r) begin
                        fill_addr_r <= fill_addr_r + ADDR_ONE;
                        if (fill_addr_r == ADDR_LAST) begin
                            fill_act_r <= 1'b0;
                        end
                    end
                    if (busy_cnt_r == BUSY_LAST) begin
                        state_r    <= ST_IDLE;
                        busy_cnt_r <= BUSY_ZERO;
                        fill_act_r <= 1'b0;
                    end else begin
                        busy_cnt_r <= busy_cnt_r + BUSY_ONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            // Output pin: read data, busy indication while selected, else ready
            case (state_r)
                ST_READ: sdo_r <= rd_bit_r;
                ST_BUSY: sdo_r <= ~scs_q_r;
                default: sdo_r <= 1'b1;
            endcase
        end
    end

    assign eeprom_sdo = sdo_r;
    assign dump_flag  = flag_r;
    assign dump_dout  = dout_r;

endmodule
